hasti_sram_ctrl: RTL

- AHB-Lite (HASTI) slave on the xbar's s1 port that maps 512 KiB of external asynchronous 16-bit SRAM (256K x 16) onto the 32-bit bus.
- Each 32-bit access is split into two sequential halfword SRAM cycles; byte and halfword accesses use a single SRAM cycle.
- Wait states are inserted via hreadyout.
- The top level owns the SRAM_DQ tristate buffer; this block exposes split data in, data out and output-enable.

---
 rtl/hasti_sram_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/hasti_sram_ctrl.sv
// AHB-Lite slave bridging 32-bit bus accesses onto a 256K x 16 asynchronous SRAM.
// Words become two halfword SRAM cycles (lo then hi); bytes/halfwords take one.
module hasti_sram_ctrl #(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [1:0]  htrans,
    input  logic        hready_in,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_o,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_i,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_SU,
        S_WR_PW,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t      state, state_n;
    logic [18:0] addr_r;
    logic [1:0]  size_r;
    logic        half_r;
    logic [3:0]  cnt;

    logic        accept, bad_req, wait_done, word_r, more, advance, active;
    logic [18:0] nxt_addr;
    logic [1:0]  nxt_size;
    logic        nxt_half, nxt_sel;
    logic        unused_bits;

    assign unused_bits = &{1'b0, haddr[31:19], htrans[0]};

    // ERR2 already drives hreadyout=1, so a pipelined address phase there must be taken.
    assign accept    = (state == S_IDLE || state == S_ERR2) && hsel && hready_in && htrans[1];
    assign bad_req   = (hsize > 3'd2) ||
                       (hsize == 3'd1 && haddr[0]) ||
                       (hsize == 3'd2 && haddr[1:0] != 2'b00);
    assign wait_done = (cnt == WS);
    assign word_r    = (size_r == 2'd2);
    assign more      = word_r && !half_r;
    assign advance   = (state == S_RD || state == S_WR_PW) && wait_done && more;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_ERR2: begin
                if (accept)
                    state_n = bad_req ? S_ERR1 : (hwrite ? S_WR_SU : S_RD);
                else
                    state_n = S_IDLE;
            end
            S_ERR1:  state_n = S_ERR2;
            S_RD:    if (wait_done) state_n = more ? S_RD : S_IDLE;
            S_WR_SU: state_n = S_WR_PW;
            S_WR_PW: if (wait_done) state_n = more ? S_WR_SU : S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Control outputs are registered, so they are derived from next-cycle values.
    always_comb begin
        nxt_addr = accept ? haddr[18:0] : addr_r;
        nxt_size = accept ? hsize[1:0] : size_r;
        nxt_half = half_r;
        if (accept)
            nxt_half = 1'b0;
        else if (advance)
            nxt_half = 1'b1;
        nxt_sel = (nxt_size == 2'd2) ? nxt_half : nxt_addr[1];
        active  = (state_n == S_RD) || (state_n == S_WR_SU) || (state_n == S_WR_PW);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r     <= '0;
            size_r     <= '0;
            half_r     <= 1'b0;
            cnt        <= '0;
            hrdata     <= '0;
            sram_addr  <= '0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
        end else begin
            addr_r <= nxt_addr;
            size_r <= nxt_size;
            half_r <= nxt_half;
            cnt    <= ((state == S_RD || state == S_WR_PW) && !wait_done) ? cnt + 4'd1 : '0;

            if (state == S_RD && wait_done) begin
                if (!word_r)
                    hrdata <= {sram_dq_i, sram_dq_i};
                else if (half_r)
                    hrdata[31:16] <= sram_dq_i;
                else
                    hrdata[15:0] <= sram_dq_i;
            end

            sram_ce_n  <= !active;
            sram_oe_n  <= (state_n != S_RD);
            sram_we_n  <= (state_n != S_WR_PW);
            sram_dq_oe <= (state_n == S_WR_SU) || (state_n == S_WR_PW);

            if (active)
                sram_addr <= {nxt_addr[18:2], nxt_sel};

            if (!active) begin
                sram_ub_n <= 1'b1;
                sram_lb_n <= 1'b1;
            end else if (state_n == S_RD || nxt_size != 2'd0) begin
                sram_ub_n <= 1'b0;
                sram_lb_n <= 1'b0;
            end else begin
                sram_ub_n <= ~nxt_addr[0];
                sram_lb_n <= nxt_addr[0];
            end
        end
    end

    assign sram_dq_o = ((size_r == 2'd2) ? half_r : addr_r[1]) ? hwdata[31:16] : hwdata[15:0];
    assign hreadyout = (state == S_IDLE) || (state == S_ERR2);
    assign hresp     = (state == S_ERR1) || (state == S_ERR2);

endmodule
